// File: rtl/candle_pkg.sv
// Shared types and widths for the candle lifecycle controller.
package candle_pkg;

  localparam int unsigned BRIGHT_W = 8;
  localparam int unsigned LFSR_W   = 4;

  typedef enum logic [2:0] {
    OFF    = 3'd0,
    IGNITE = 3'd1,
    BURN   = 3'd2,
    GUST   = 3'd3,
    GUTTER = 3'd4
  } state_t;

  function automatic logic [BRIGHT_W-1:0] min_bright(
    input logic [BRIGHT_W-1:0] a,
    input logic [BRIGHT_W-1:0] b
  );
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/candle_sequencer_sat_ramp.sv
// Saturating ramp step: adds or subtracts a step, clamping at full scale or zero.
module sat_ramp
  import candle_pkg::*;
(
  input  logic [BRIGHT_W-1:0] value,
  input  logic [BRIGHT_W-1:0] step,
  input  logic                up,
  output logic [BRIGHT_W-1:0] result
);

  logic [BRIGHT_W:0] sum;

  always_comb begin
    sum = {1'b0, value} + {1'b0, step};
    if (up) begin
      result = sum[BRIGHT_W] ? '1 : sum[BRIGHT_W-1:0];
    end else begin
      result = (value > step) ? (value - step) : '0;
    end
  end

endmodule

// File: rtl/candle_sequencer.sv
// Candle lifecycle FSM: off, ignite fade-in, burn pass-through, gust dim, gutter fade-out.
module candle_sequencer
  import candle_pkg::*;
#(
  parameter int unsigned       RAMP_STEP  = 4,
  parameter logic [LFSR_W-1:0] GUST_CODE  = 4'hF,
  parameter int unsigned       GUST_TICKS = 8,
  parameter int unsigned       GUST_SHIFT = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tick,
  input  logic                light_req,
  input  logic [LFSR_W-1:0]   lfsr,
  input  logic [BRIGHT_W-1:0] flkr_in,
  output logic [BRIGHT_W-1:0] brightness,
  output logic [2:0]          state,
  output logic                busy
);

  localparam logic [BRIGHT_W-1:0] STEP     = RAMP_STEP[BRIGHT_W-1:0];
  localparam logic [BRIGHT_W-1:0] GUST_LEN = GUST_TICKS[BRIGHT_W-1:0];

  state_t              state_q, state_d;
  logic [BRIGHT_W-1:0] level_q, level_d;
  logic [BRIGHT_W-1:0] gust_cnt_q, gust_cnt_d;
  logic [BRIGHT_W-1:0] bright_d;
  logic [BRIGHT_W-1:0] ramp_out;
  logic [BRIGHT_W-1:0] gust_dim;

  sat_ramp u_ramp (
    .value  (level_q),
    .step   (STEP),
    .up     (state_q == IGNITE),
    .result (ramp_out)
  );

  assign gust_dim = flkr_in >> GUST_SHIFT;
  assign state    = state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= OFF;
      level_q    <= '0;
      gust_cnt_q <= '0;
      brightness <= '0;
    end else begin
      state_q    <= state_d;
      level_q    <= level_d;
      gust_cnt_q <= gust_cnt_d;
      brightness <= bright_d;
    end
  end

  // light_req edges are tested before tick so they always win a same-cycle tie.
  always_comb begin
    state_d    = state_q;
    level_d    = level_q;
    gust_cnt_d = gust_cnt_q;
    case (state_q)
      OFF: begin
        level_d    = '0;
        gust_cnt_d = '0;
        if (light_req) state_d = IGNITE;
      end
      IGNITE: begin
        if (!light_req) begin
          state_d = GUTTER;
        end else if (tick) begin
          level_d = ramp_out;
          if (ramp_out >= flkr_in) state_d = BURN;
        end
      end
      BURN: begin
        level_d = '1;
        if (!light_req) begin
          state_d = GUTTER;
          level_d = flkr_in;
        end else if (tick && (lfsr == GUST_CODE)) begin
          state_d    = GUST;
          gust_cnt_d = GUST_LEN;
        end
      end
      GUST: begin
        if (!light_req) begin
          state_d    = GUTTER;
          level_d    = gust_dim;
          gust_cnt_d = '0;
        end else if (tick) begin
          gust_cnt_d = gust_cnt_q - 8'd1;
          if (gust_cnt_q == 8'd1) state_d = BURN;
        end
      end
      GUTTER: begin
        if (light_req) begin
          state_d = IGNITE;
        end else if (tick) begin
          level_d = ramp_out;
          if (ramp_out == '0) state_d = OFF;
        end
      end
      default: begin
        state_d    = OFF;
        level_d    = '0;
        gust_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    bright_d = '0;
    busy     = 1'b0;
    case (state_q)
      IGNITE: begin
        bright_d = min_bright(level_q, flkr_in);
        busy     = 1'b1;
      end
      GUTTER: begin
        bright_d = min_bright(level_q, flkr_in);
        busy     = 1'b1;
      end
      BURN:    bright_d = flkr_in;
      GUST:    bright_d = gust_dim;
      default: bright_d = '0;
    endcase
  end

endmodule

// File: tb/tb_candle_sequencer.sv
// Directed lifecycle checks followed by random stimulus against a behavioural model.
module tb_candle_sequencer;
  import candle_pkg::*;

  localparam int STEP  = 4;
  localparam int CODE  = 15;
  localparam int TICKS = 8;
  localparam int SHIFT = 1;

  logic       clk = 1'b0;
  logic       reset, tick, light_req;
  logic [3:0] lfsr;
  logic [7:0] flkr_in;
  logic [7:0] brightness;
  logic [2:0] state;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  int m_st, m_level, m_gcnt, m_bright;

  candle_sequencer #(
    .RAMP_STEP  (STEP),
    .GUST_CODE  (4'hF),
    .GUST_TICKS (TICKS),
    .GUST_SHIFT (SHIFT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .light_req  (light_req),
    .lfsr       (lfsr),
    .flkr_in    (flkr_in),
    .brightness (brightness),
    .state      (state),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    assert (act === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Model phases: 0 off, 1 ignite, 2 burn, 3 gust, 4 gutter; anything else illegal.
  task automatic model_edge();
    int nb, ns, nl, ng;
    if (reset) begin
      m_st = 0; m_level = 0; m_gcnt = 0; m_bright = 0;
      return;
    end
    nb = 0; ns = m_st; nl = m_level; ng = m_gcnt;
    case (m_st)
      0: begin
        nl = 0; ng = 0;
        if (light_req) ns = 1;
      end
      1: begin
        nb = imin(m_level, int'(flkr_in));
        if (!light_req) ns = 4;
        else if (tick) begin
          nl = imin(m_level + STEP, 255);
          if (nl >= int'(flkr_in)) ns = 2;
        end
      end
      2: begin
        nb = flkr_in;
        nl = 255;
        if (!light_req) begin ns = 4; nl = flkr_in; end
        else if (tick && int'(lfsr) == CODE) begin ns = 3; ng = TICKS; end
      end
      3: begin
        nb = int'(flkr_in) >> SHIFT;
        if (!light_req) begin ns = 4; nl = int'(flkr_in) >> SHIFT; ng = 0; end
        else if (tick) begin
          ng = m_gcnt - 1;
          if (ng == 0) ns = 2;
        end
      end
      4: begin
        nb = imin(m_level, int'(flkr_in));
        if (light_req) ns = 1;
        else if (tick) begin
          nl = imax(m_level - STEP, 0);
          if (nl == 0) ns = 0;
        end
      end
      default: begin ns = 0; nl = 0; ng = 0; end
    endcase
    m_st = ns; m_level = nl; m_gcnt = ng; m_bright = nb;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    chk("m_bright", brightness, m_bright);
    chk("m_state", state, m_st);
    chk("m_busy", busy, (m_st == 1 || m_st == 4) ? 1 : 0);
  endtask

  task automatic tick_then_idle(input int idle);
    tick = 1'b1; cyc();
    tick = 1'b0;
    for (int i = 0; i < idle; i++) cyc();
  endtask

  task automatic ramp_to_burn();
    for (int i = 0; i < 80 && m_st != 2; i++) tick_then_idle(0);
    chk("reach_burn", state, 2);
  endtask

  initial begin
    reset = 1'b1; light_req = 1'b1; tick = 1'b0; lfsr = 4'h0; flkr_in = 8'd20;
    m_st = 0; m_level = 0; m_gcnt = 0; m_bright = 0;

    for (int i = 0; i < 3; i++) begin
      tick = ~tick;
      cyc();
      chk("rst_bright", brightness, 0);
      chk("rst_state", state, 0);
    end
    reset = 1'b0; tick = 1'b0;
    cyc();
    chk("rel_state", state, 1);

    for (int k = 1; k <= 5; k++) begin
      tick = 1'b1; cyc(); tick = 1'b0;
      if (k == 5) begin
        chk("ign_burn_state", state, 2);
        chk("ign_busy_fall", busy, 0);
      end
      for (int i = 0; i < 3; i++) cyc();
      chk("ign_bright", brightness, (k < 5) ? 4 * k : 20);
    end

    flkr_in = 8'd200; cyc();
    chk("burn_pass", brightness, 200);
    lfsr = 4'hE; tick_then_idle(0);
    chk("no_gust", state, 2);
    lfsr = 4'hF; tick = 1'b1; cyc(); tick = 1'b0; lfsr = 4'h0;
    chk("gust_state", state, 3);
    cyc();
    chk("gust_bright", brightness, 100);
    for (int i = 1; i <= 8; i++) begin
      tick_then_idle(1);
      chk("gust_len", state, (i < 8) ? 3 : 2);
    end
    chk("gust_end_bright", brightness, 200);

    flkr_in = 8'd10; cyc();
    light_req = 1'b0; cyc();
    chk("gut_state", state, 4);
    cyc();
    chk("gut_bright0", brightness, 10);
    tick_then_idle(1); chk("gut_bright1", brightness, 6);
    tick_then_idle(0); chk("gut_state2", state, 4);
    cyc();             chk("gut_bright2", brightness, 2);
    tick_then_idle(0); chk("gut_off", state, 0);
    cyc();             chk("gut_bright3", brightness, 0);
    tick_then_idle(2); chk("gut_no_uflow", brightness, 0);

    light_req = 1'b1; cyc();
    ramp_to_burn();
    light_req = 1'b0; cyc();
    flkr_in = 8'd30;
    tick_then_idle(0);
    chk("relight_pre", state, 4);
    light_req = 1'b1; cyc();
    chk("relight_state", state, 1);
    cyc();
    chk("relight_hold", brightness, 6);
    tick_then_idle(2); chk("relight_ramp1", brightness, 10);
    tick_then_idle(2); chk("relight_ramp2", brightness, 14);

    ramp_to_burn();
    tick = 1'b1; lfsr = 4'hF; light_req = 1'b0; cyc();
    tick = 1'b0; lfsr = 4'h0;
    chk("prio_gutter", state, 4);

    light_req = 1'b1; cyc();
    ramp_to_burn();
    force dut.state_q = state_t'(3'd7);
    #1;
    chk("force_state", state, 7);
    release dut.state_q;
    m_st = 7;
    cyc();
    chk("illegal_off", state, 0);
    cyc();

    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 299) == 0);
      tick  = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 39) == 0) light_req = ~light_req;
      lfsr    = 4'($urandom_range(0, 15));
      flkr_in = 8'($urandom_range(0, 255));
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
